// File: rtl/ro_freq_counter_if.sv
// rtl/ro_freq_counter_if.sv - Wishbone classic slave bundle for ro_freq_counter
interface ro_freq_counter_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ro_freq_counter.sv
// rtl/ro_freq_counter.sv - ring-oscillator edge counter with Wishbone registers; optional irq via RO_FREQ_COUNTER_IRQ_EN
module ro_freq_counter #(
  parameter int          CNT_W         = 24,
  parameter int          GATE_W        = 24,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  ro_freq_counter_if.slave   wbs,
  input  logic               ro_in,
  output logic [4:0]         ro_s,
  output logic               ro_start,
  output logic [3:0]         ro_sel
`ifdef RO_FREQ_COUNTER_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    LATCH   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         ro_sync;
  logic               rise;

  logic [4:0]         chain_q;
  logic [3:0]         msel_q;
  logic               cont_q;
  logic [GATE_W-1:0]  gate_reg_q;
  logic [CNT_W-1:0]   count_q;
  logic               done_q;
  logic               ovf_q;
`ifdef RO_FREQ_COUNTER_IRQ_EN
  logic               irqen_q;
`endif

  logic [SET_W-1:0]   settle_q;
  logic [GATE_W-1:0]  gate_q;
  logic [GATE_W-1:0]  gate_load;
  logic [CNT_W-1:0]   edge_q;
  logic [CNT_W-1:0]   edge_nx;
  logic               edge_sat;
  logic               ovf_set;

  logic               ld_settle, ld_gate, latch_en, cnt_en;

  logic               ack_q;
  logic [31:0]        dat_q;
  logic [31:0]        rdata;
  logic               adr_hit, req, wr;
  logic [1:0]         reg_idx;
  logic               ctrl_wr, gate_wr, status_wr;
  logic               go_wr, abort_wr;
  logic               busy;
  logic               unused_bits;

  assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i};

  // Two-flop synchronizer plus a third stage for rising-edge detection
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ro_sync <= '0;
    end else begin
      ro_sync <= {ro_sync[1:0], ro_in};
    end
  end

  assign rise = ro_sync[1] & ~ro_sync[2];

  // Bus decode: a new request is accepted only while ack is low
  assign adr_hit   = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req       = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q & adr_hit;
  assign wr        = req & wbs.wbs_we_i & (wbs.wbs_sel_i == 4'hF);
  assign reg_idx   = wbs.wbs_adr_i[3:2];
  assign ctrl_wr   = wr & (reg_idx == 2'd0);
  assign gate_wr   = wr & (reg_idx == 2'd1);
  assign status_wr = wr & (reg_idx == 2'd3);
  assign abort_wr  = ctrl_wr & wbs.wbs_dat_i[11];
  assign go_wr     = ctrl_wr & wbs.wbs_dat_i[0] & ~wbs.wbs_dat_i[11];
  assign busy      = (state_q != IDLE);

  // A zero gate length still measures for one cycle
  assign gate_load = (gate_reg_q == '0) ? '0 : gate_reg_q - GATE_W'(1);

  // Saturating edge increment; an increment attempted at all-ones flags overflow
  assign edge_sat = &edge_q;
  assign edge_nx  = (cnt_en && rise && !edge_sat) ? edge_q + CNT_W'(1) : edge_q;
  assign ovf_set  = cnt_en & rise & edge_sat;

  // Register read multiplexer
  always_comb begin
    rdata = '0;
    case (reg_idx)
      2'd0: begin
        rdata[1]    = cont_q;
        rdata[6:2]  = chain_q;
        rdata[10:7] = msel_q;
`ifdef RO_FREQ_COUNTER_IRQ_EN
        rdata[12]   = irqen_q;
`endif
      end
      2'd1:    rdata = 32'(gate_reg_q);
      2'd2:    rdata = 32'(count_q);
      default: rdata = {27'd0, state_q, ovf_q, done_q, busy};
    endcase
  end

  // Registered single-cycle acknowledge with read data only during ack
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs.wbs_we_i) ? rdata : '0;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

  // Measurement state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter control; ABORT overrides every other transition
  always_comb begin
    state_d   = state_q;
    ld_settle = 1'b0;
    ld_gate   = 1'b0;
    latch_en  = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_wr) begin
          state_d   = SETTLE;
          ld_settle = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = MEASURE;
          ld_gate = 1'b1;
        end
      end
      MEASURE: begin
        cnt_en = 1'b1;
        if (gate_q == '0) begin
          state_d  = LATCH;
          latch_en = 1'b1;
        end
      end
      LATCH: begin
        if (cont_q) begin
          state_d = MEASURE;
          ld_gate = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (abort_wr) begin
      state_d   = IDLE;
      ld_settle = 1'b0;
      ld_gate   = 1'b0;
      latch_en  = 1'b0;
      cnt_en    = 1'b0;
    end
  end

  // Settle, gate and edge counters
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      settle_q <= '0;
      gate_q   <= '0;
      edge_q   <= '0;
    end else begin
      if (ld_settle) begin
        settle_q <= SETTLE_LOAD;
      end else if (state_q == SETTLE && settle_q != '0) begin
        settle_q <= settle_q - SET_W'(1);
      end
      if (ld_gate) begin
        gate_q <= gate_load;
      end else if (state_q == MEASURE && gate_q != '0) begin
        gate_q <= gate_q - GATE_W'(1);
      end
      if (ld_gate) begin
        edge_q <= '0;
      end else if (cnt_en) begin
        edge_q <= edge_nx;
      end
    end
  end

  // Software registers; result captured with the final-cycle edge included, hardware sets beat W1C
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      chain_q    <= '0;
      msel_q     <= '0;
      cont_q     <= 1'b0;
      gate_reg_q <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef RO_FREQ_COUNTER_IRQ_EN
      irqen_q    <= 1'b0;
`endif
    end else begin
      if (ctrl_wr && state_q == IDLE) begin
        chain_q <= wbs.wbs_dat_i[6:2];
        msel_q  <= wbs.wbs_dat_i[10:7];
      end
      if (abort_wr) begin
        cont_q <= 1'b0;
      end else if (ctrl_wr) begin
        cont_q <= wbs.wbs_dat_i[1];
      end
`ifdef RO_FREQ_COUNTER_IRQ_EN
      if (ctrl_wr) begin
        irqen_q <= wbs.wbs_dat_i[12];
      end
`endif
      if (gate_wr) begin
        gate_reg_q <= wbs.wbs_dat_i[GATE_W-1:0];
      end
      if (latch_en) begin
        count_q <= edge_nx;
      end
      if (latch_en) begin
        done_q <= 1'b1;
      end else if (status_wr && wbs.wbs_dat_i[1]) begin
        done_q <= 1'b0;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (status_wr && wbs.wbs_dat_i[2]) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef RO_FREQ_COUNTER_IRQ_EN
  // Interrupt is a registered copy of DONE gated by its enable
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq <= 1'b0;
    end else begin
      irq <= done_q & irqen_q;
    end
  end
`endif

  assign ro_s     = chain_q;
  assign ro_sel   = msel_q;
  assign ro_start = busy;

endmodule

// File: tb/tb_ro_freq_counter.sv
// tb/tb_ro_freq_counter.sv - self-checking bench for ro_freq_counter
module tb_ro_freq_counter;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        ro_in;
  int          ro_per;
  int          cyc_n = 0;
  int          last_ack_cyc;
  int          checks = 0;
  int          errors = 0;

  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;

  logic [4:0]  ro_s0, ro_s1;
  logic        ro_start0, ro_start1;
  logic [3:0]  ro_sel0, ro_sel1;
`ifdef RO_FREQ_COUNTER_IRQ_EN
  logic        irq0, irq1;
`endif

  ro_freq_counter_if bus0 ();
  ro_freq_counter_if bus1 ();

  assign bus0.wbs_cyc_i = m_cyc;
  assign bus0.wbs_stb_i = m_stb;
  assign bus0.wbs_we_i  = m_we;
  assign bus0.wbs_adr_i = m_adr;
  assign bus0.wbs_dat_i = m_dat;
  assign bus0.wbs_sel_i = m_sel;
  assign bus1.wbs_cyc_i = m_cyc;
  assign bus1.wbs_stb_i = m_stb;
  assign bus1.wbs_we_i  = m_we;
  assign bus1.wbs_adr_i = m_adr;
  assign bus1.wbs_dat_i = m_dat;
  assign bus1.wbs_sel_i = m_sel;

  ro_freq_counter #(.CNT_W(24)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus0.slave), .ro_in(ro_in),
    .ro_s(ro_s0), .ro_start(ro_start0), .ro_sel(ro_sel0)
`ifdef RO_FREQ_COUNTER_IRQ_EN
    , .irq(irq0)
`endif
  );

  ro_freq_counter #(.CNT_W(4)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus1.slave), .ro_in(ro_in),
    .ro_s(ro_s1), .ro_start(ro_start1), .ro_sel(ro_sel1)
`ifdef RO_FREQ_COUNTER_IRQ_EN
    , .irq(irq1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n++;

  // Oscillator model: square wave of ro_per clock cycles, held low when ro_per < 2
  initial begin
    ro_in = 1'b0;
    forever begin
      if (ro_per < 2) begin
        ro_in = 1'b0;
        @(negedge clk);
      end else begin
        ro_in = 1'b1;
        repeat (ro_per / 2) @(negedge clk);
        ro_in = 1'b0;
        repeat (ro_per - ro_per / 2) @(negedge clk);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data, input logic [3:0] s);
    int n;
    logic a;
    @(negedge clk);
    m_adr = BASE + off; m_dat = data; m_sel = s; m_we = 1'b1; m_cyc = 1'b1; m_stb = 1'b1;
    n = 0; a = 1'b0;
    while (!a && n < 10) begin
      @(negedge clk);
      n++;
      a = bus0.wbs_ack_o;
    end
    last_ack_cyc = cyc_n;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    chk("wr_ack", 32'(a), 32'd1);
  endtask

  task automatic bus_read(input int d, input logic [31:0] off, output logic [31:0] data);
    int n;
    logic a;
    @(negedge clk);
    m_adr = BASE + off; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    n = 0; a = 1'b0;
    while (!a && n < 10) begin
      @(negedge clk);
      n++;
      a = (d == 1) ? bus1.wbs_ack_o : bus0.wbs_ack_o;
    end
    data = (d == 1) ? bus1.wbs_dat_o : bus0.wbs_dat_o;
    last_ack_cyc = cyc_n;
    m_cyc = 1'b0; m_stb = 1'b0;
    chk("rd_ack", 32'(a), 32'd1);
  endtask

  task automatic wait_done(input int d, input int budget, output int t_seen);
    logic [31:0] s;
    int t0;
    t0 = cyc_n;
    t_seen = -1;
    while (t_seen < 0 && (cyc_n - t0) < budget) begin
      bus_read(d, 32'hC, s);
      if (s[1]) t_seen = last_ack_cyc;
    end
    chk("done_seen", 32'(t_seen >= 0), 32'd1);
  endtask

  // Reference: G consecutive cycles of a period-P wave hold floor or ceil of G/P rising edges
  function automatic int edges_lo(input int per, input int g);
    int ge;
    ge = (g == 0) ? 1 : g;
    return (per < 2) ? 0 : ge / per;
  endfunction

  function automatic int edges_hi(input int per, input int g);
    int ge;
    ge = (g == 0) ? 1 : g;
    return (per < 2) ? 0 : (ge + per - 1) / per;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] off;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[18];

  task automatic setv(input int i, input logic we, input logic [31:0] off, input logic [31:0] wd,
                      input logic [3:0] s, input logic [31:0] exp, input string name);
    tbl[i].we = we; tbl[i].off = off; tbl[i].wdata = wd;
    tbl[i].sel = s; tbl[i].exp = exp; tbl[i].name = name;
  endtask

  initial begin
    logic [31:0] rd, c0, ctrl_full;
    int t, tgo, t1, t2;
    logic got;
    int n;

`ifdef RO_FREQ_COUNTER_IRQ_EN
    ctrl_full = 32'h17FE;
`else
    ctrl_full = 32'h07FE;
`endif
    setv(0,  0, 32'h0, 32'h0,        4'hF, 32'h0,        "rst_ctrl");
    setv(1,  0, 32'h4, 32'h0,        4'hF, 32'h0,        "rst_gate");
    setv(2,  0, 32'h8, 32'h0,        4'hF, 32'h0,        "rst_count");
    setv(3,  0, 32'hC, 32'h0,        4'hF, 32'h0,        "rst_status");
    setv(4,  1, 32'h4, 32'h00123456, 4'hF, 32'h0,        "");
    setv(5,  0, 32'h4, 32'h0,        4'hF, 32'h00123456, "gate_rb");
    setv(6,  1, 32'h4, 32'hFFFFFFFF, 4'hF, 32'h0,        "");
    setv(7,  0, 32'h4, 32'h0,        4'hF, 32'h00FFFFFF, "gate_width");
    setv(8,  1, 32'h0, 32'h000017FE, 4'hF, 32'h0,        "");
    setv(9,  0, 32'h0, 32'h0,        4'hF, ctrl_full,    "ctrl_rb");
    setv(10, 1, 32'h0, 32'h0,        4'h3, 32'h0,        "");
    setv(11, 0, 32'h0, 32'h0,        4'hF, ctrl_full,    "ctrl_partial_sel");
    setv(12, 1, 32'h8, 32'h00000055, 4'hF, 32'h0,        "");
    setv(13, 0, 32'h8, 32'h0,        4'hF, 32'h0,        "count_ro");
    setv(14, 1, 32'h0, 32'h0,        4'hF, 32'h0,        "");
    setv(15, 0, 32'h0, 32'h0,        4'hF, 32'h0,        "ctrl_clear");
    setv(16, 1, 32'h4, 32'h0,        4'hF, 32'h0,        "");
    setv(17, 0, 32'h4, 32'h0,        4'hF, 32'h0,        "gate_zero");

    m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_dat = '0; m_sel = '0;
    ro_per = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ro_start", 32'(ro_start0), 32'd0);
    chk("rst_ro_s", 32'(ro_s0), 32'd0);
    chk("rst_ro_sel", 32'(ro_sel0), 32'd0);
    chk("rst_ack", 32'(bus0.wbs_ack_o), 32'd0);
    chk("rst_dat", bus0.wbs_dat_o, 32'd0);
    rst = 1'b0;

    // Register table
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].we) begin
        bus_write(tbl[i].off, tbl[i].wdata, tbl[i].sel);
      end else begin
        bus_read(0, tbl[i].off, rd);
        chk(tbl[i].name, rd, tbl[i].exp);
      end
    end

    // Main measurement: clk/10 over 1000 cycles
    ro_per = 10;
    bus_write(32'h4, 32'd1000, 4'hF);
    bus_write(32'h0, 32'h185, 4'hF);
    tgo = last_ack_cyc;
    chk("main_ro_s", 32'(ro_s0), 32'd1);
    chk("main_ro_sel", 32'(ro_sel0), 32'd3);
    chk("main_ro_start", 32'(ro_start0), 32'd1);
    wait_done(0, 1200, t);
    chk_rng("main_done_time", t - tgo, 1016, 1019);
    bus_read(0, 32'h8, rd);
    chk_rng("main_count", int'(rd), 99, 101);
    bus_read(0, 32'hC, rd);
    chk("main_status", rd, 32'h2);
    chk("main_ro_start_end", 32'(ro_start0), 32'd0);

    // Reset in the middle of a measurement
    bus_write(32'h0, 32'h185, 4'hF);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ro_start", 32'(ro_start0), 32'd0);
    chk("midrst_ro_s", 32'(ro_s0), 32'd0);
    rst = 1'b0;
    bus_read(0, 32'h8, rd);
    chk("midrst_count", rd, 32'h0);
    bus_read(0, 32'hC, rd);
    chk("midrst_status", rd, 32'h0);
    bus_read(0, 32'h4, rd);
    chk("midrst_gate", rd, 32'h0);

    // Saturation on the narrow counter instance
    ro_per = 4;
    bus_write(32'h4, 32'd200, 4'hF);
    bus_write(32'h0, 32'h1, 4'hF);
    wait_done(1, 300, t);
    bus_read(1, 32'h8, rd);
    chk("ovf_count", rd, 32'd15);
    bus_read(1, 32'hC, rd);
    chk("ovf_flags", rd & 32'h6, 32'h6);
    bus_read(0, 32'h8, rd);
    chk_rng("wide_count", int'(rd), 49, 51);
    bus_write(32'hC, 32'h6, 4'hF);
    bus_read(1, 32'hC, rd);
    chk("ovf_w1c", rd, 32'h0);

    // Continuous mode, then abort mid-window
    ro_per = 5;
    bus_write(32'h4, 32'd50, 4'hF);
    bus_write(32'h0, 32'h7, 4'hF);
    wait_done(0, 200, t1);
    bus_read(0, 32'h8, rd);
    chk_rng("cont_count1", int'(rd), 9, 11);
    bus_write(32'hC, 32'h2, 4'hF);
    wait_done(0, 200, t2);
    chk_rng("cont_period", t2 - t1, 47, 55);
    bus_read(0, 32'h8, rd);
    chk_rng("cont_count2", int'(rd), 9, 11);
    bus_write(32'hC, 32'h2, 4'hF);
    repeat (20) @(negedge clk);
    bus_read(0, 32'h8, c0);
    bus_write(32'h0, 32'h800, 4'hF);
    bus_read(0, 32'hC, rd);
    chk("abort_idle", rd & 32'h19, 32'h0);
    bus_read(0, 32'h8, rd);
    chk("abort_count_kept", rd, c0);
    repeat (120) @(negedge clk);
    bus_read(0, 32'hC, rd);
    chk("abort_stays_idle", rd, 32'h0);
    bus_read(0, 32'h0, rd);
    chk("abort_cont_cleared", rd, 32'h4);

    // GO and MSEL changes during MEASURE are ignored
    ro_per = 0;
    bus_write(32'h4, 32'd300, 4'hF);
    bus_write(32'h0, 32'h289, 4'hF);
    tgo = last_ack_cyc;
    repeat (40) @(negedge clk);
    bus_write(32'h0, 32'h48D, 4'hF);
    chk("busy_ro_sel", 32'(ro_sel0), 32'd5);
    chk("busy_ro_s", 32'(ro_s0), 32'd2);
    wait_done(0, 400, t);
    chk_rng("busy_go_no_restart", t - tgo, 316, 319);
    bus_read(0, 32'h8, rd);
    chk("static_count", rd, 32'h0);
    bus_read(0, 32'h0, rd);
    chk("busy_ctrl_kept", rd, 32'h288);
    bus_write(32'hC, 32'h6, 4'hF);

    // Unmapped address is never acknowledged
    @(negedge clk);
    m_adr = BASE + 32'h10; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    got = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus0.wbs_ack_o) got = 1'b1;
    end
    chk("unmapped_ack", 32'(got), 32'd0);
    chk("unmapped_dat", bus0.wbs_dat_o, 32'd0);
    m_adr = BASE + 32'h8;
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      got = bus0.wbs_ack_o;
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    chk("count_ack_latency", 32'(n), 32'd1);
    @(negedge clk);
    chk("ack_single", 32'(bus0.wbs_ack_o), 32'd0);

    // Randomized measurements against the edge-count model
    for (int it = 0; it < 8; it++) begin
      int per, g, ge, lo, hi, sl;
      logic [31:0] c1, s1;
      per = $urandom_range(0, 12);
      if (per < 3) per = 0;
      g = $urandom_range(0, 300);
      ge = (g == 0) ? 1 : g;
      lo = edges_lo(per, g);
      hi = edges_hi(per, g);
      sl = (per == 0) ? 0 : 1;
      ro_per = per;
      bus_write(32'h4, 32'(g), 4'hF);
      bus_write(32'h0, 32'h1, 4'hF);
      tgo = last_ack_cyc;
      wait_done(0, g + 80, t);
      chk_rng("rand_done_time", t - tgo, ge + 16, ge + 19);
      bus_read(0, 32'h8, rd);
      chk_rng("rand_count", int'(rd), imax(lo - sl, 0), hi + sl);
      bus_read(1, 32'h8, c1);
      chk_rng("rand_count_w4", int'(c1), imin(imax(lo - sl, 0), 15), imin(hi + sl, 15));
      bus_read(1, 32'hC, s1);
      if (lo - sl >= 16) chk("rand_ovf_w4", 32'(s1[2]), 32'd1);
      else if (hi + sl <= 15) chk("rand_ovf_w4", 32'(s1[2]), 32'd0);
      bus_write(32'hC, 32'h6, 4'hF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
